// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, memory-wait freeze, branch flush and a
// RUN/DRAIN/HALTED halt controller driving every stage register's enables.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 8,
    parameter int STALL_W      = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [3:0]         i_id_registerA,
    input  logic [3:0]         i_id_registerB,
    input  logic               i_id_useA,
    input  logic               i_id_useB,
    input  logic               i_id_ex_memRead,
    input  logic [3:0]         i_id_ex_registerRD,
    input  logic               i_branch_taken,
    input  logic               i_mem_busy,
    input  logic               i_halt_req,
    input  logic               i_resume,
    output logic               o_pc_write,
    output logic               o_if_id_write,
    output logic               o_if_id_flush,
    output logic               o_id_ex_write,
    output logic               o_id_ex_bubble,
    output logic               o_ex_mem_write,
    output logic               o_mem_wb_bubble,
    output logic               o_halted,
    output logic               o_mem_error,
    output logic [STALL_W-1:0] o_stall_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] TO_LAST    = 8'(MEM_TIMEOUT - 1);
    localparam logic [7:0] TO_MAX     = 8'(MEM_TIMEOUT);

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_drain_cnt;
    logic [7:0]         r_to_cnt;
    logic               r_mem_error;
    logic [STALL_W-1:0] r_stall_count;

    logic w_load_use;
    logic w_drain_adv;

    // No R0 exclusion: every register number is a real hazard candidate.
    assign w_load_use = i_id_ex_memRead &
                        ((i_id_useA & (i_id_ex_registerRD == i_id_registerA)) |
                         (i_id_useB & (i_id_ex_registerRD == i_id_registerB)));

    always_comb begin
        o_pc_write      = 1'b1;
        o_if_id_write   = 1'b1;
        o_if_id_flush   = 1'b0;
        o_id_ex_write   = 1'b1;
        o_id_ex_bubble  = 1'b0;
        o_ex_mem_write  = 1'b1;
        o_mem_wb_bubble = 1'b0;
        o_halted        = 1'b0;
        w_state_next    = r_state;
        w_drain_adv     = 1'b0;

        if (i_mem_busy) begin
            // Freeze holds every stage in every state; nothing advances.
            o_pc_write      = 1'b0;
            o_if_id_write   = 1'b0;
            o_id_ex_write   = 1'b0;
            o_ex_mem_write  = 1'b0;
            o_mem_wb_bubble = 1'b1;
            o_halted        = (r_state == ST_HALTED);
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_branch_taken) begin
                        o_if_id_flush  = 1'b1;
                        o_id_ex_bubble = 1'b1;
                    end else if (w_load_use) begin
                        o_pc_write     = 1'b0;
                        o_if_id_write  = 1'b0;
                        o_id_ex_bubble = 1'b1;
                    end else if (i_halt_req) begin
                        w_state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    o_pc_write    = 1'b0;
                    o_if_id_flush = 1'b1;
                    if (i_branch_taken) begin
                        o_pc_write     = 1'b1;
                        o_id_ex_bubble = 1'b1;
                        w_drain_adv    = 1'b1;
                    end else if (w_load_use) begin
                        o_if_id_write  = 1'b0;
                        o_if_id_flush  = 1'b0;
                        o_id_ex_bubble = 1'b1;
                    end else begin
                        w_drain_adv = 1'b1;
                    end
                    if (w_drain_adv && (r_drain_cnt == DRAIN_LAST)) begin
                        w_state_next = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    o_pc_write     = 1'b0;
                    o_if_id_write  = 1'b0;
                    o_id_ex_bubble = 1'b1;
                    o_halted       = 1'b1;
                    if (i_resume) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end

        if (i_reset) begin
            o_pc_write      = 1'b0;
            o_if_id_write   = 1'b0;
            o_if_id_flush   = 1'b0;
            o_id_ex_write   = 1'b0;
            o_id_ex_bubble  = 1'b1;
            o_ex_mem_write  = 1'b0;
            o_mem_wb_bubble = 1'b1;
            o_halted        = 1'b0;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_RUN;
            r_drain_cnt   <= 4'd0;
            r_to_cnt      <= 8'd0;
            r_mem_error   <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_next;

            if (r_state != ST_DRAIN) begin
                r_drain_cnt <= 4'd0;
            end else if (w_drain_adv) begin
                r_drain_cnt <= r_drain_cnt + 4'd1;
            end

            if (!i_mem_busy) begin
                r_to_cnt <= 8'd0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end

            // Set at the edge that closes the MEM_TIMEOUT-th consecutive busy cycle.
            if (i_mem_busy && (r_to_cnt == TO_LAST)) begin
                r_mem_error <= 1'b1;
            end

            if ((r_state == ST_RUN) && !o_pc_write && (r_stall_count != {STALL_W{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign o_mem_error   = r_mem_error;
    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each cycle's expected control
// vector is queued with its stimulus and compared before the next clock edge.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        i_reset;
    logic [3:0]  i_id_registerA, i_id_registerB, i_id_ex_registerRD;
    logic        i_id_useA, i_id_useB, i_id_ex_memRead;
    logic        i_branch_taken, i_mem_busy, i_halt_req, i_resume;
    logic        o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_write;
    logic        o_id_ex_bubble, o_ex_mem_write, o_mem_wb_bubble, o_halted, o_mem_error;
    logic [15:0] o_stall_count;

    int vectors = 0;
    int miscompares = 0;
    logic [24:0] sb[$];
    logic [24:0] exp_v, got_v;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble}
    localparam logic [6:0] NORM = 7'b1101010;
    localparam logic [6:0] FRZ  = 7'b0000001;
    localparam logic [6:0] BR   = 7'b1111110;
    localparam logic [6:0] LU   = 7'b0001110;
    localparam logic [6:0] DRN  = 7'b0111010;
    localparam logic [6:0] HLT  = 7'b0001110;
    localparam logic [6:0] RST  = 7'b0000101;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .MEM_TIMEOUT(8), .STALL_W(16)) dut (
        .i_clock(clk), .i_reset(i_reset),
        .i_id_registerA(i_id_registerA), .i_id_registerB(i_id_registerB),
        .i_id_useA(i_id_useA), .i_id_useB(i_id_useB),
        .i_id_ex_memRead(i_id_ex_memRead), .i_id_ex_registerRD(i_id_ex_registerRD),
        .i_branch_taken(i_branch_taken), .i_mem_busy(i_mem_busy),
        .i_halt_req(i_halt_req), .i_resume(i_resume),
        .o_pc_write(o_pc_write), .o_if_id_write(o_if_id_write), .o_if_id_flush(o_if_id_flush),
        .o_id_ex_write(o_id_ex_write), .o_id_ex_bubble(o_id_ex_bubble),
        .o_ex_mem_write(o_ex_mem_write), .o_mem_wb_bubble(o_mem_wb_bubble),
        .o_halted(o_halted), .o_mem_error(o_mem_error), .o_stall_count(o_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] E(input logic [6:0] c, input logic h, input logic m, input int st);
        logic [15:0] s16;
        s16 = st[15:0];
        return {c, h, m, s16};
    endfunction

    function automatic logic [24:0] observe();
        return {o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_write, o_id_ex_bubble,
                o_ex_mem_write, o_mem_wb_bubble, o_halted, o_mem_error, o_stall_count};
    endfunction

    // Drives one cycle of inputs (low clock phase), queues its expectation, lets logic settle.
    task automatic drive(input logic mr, input logic [3:0] rd, input logic [3:0] ra, input logic ua,
                         input logic [3:0] rb, input logic ub, input logic br, input logic busy,
                         input logic halt, input logic res, input logic [24:0] e);
        i_id_ex_memRead = mr; i_id_ex_registerRD = rd;
        i_id_registerA = ra; i_id_useA = ua; i_id_registerB = rb; i_id_useB = ub;
        i_branch_taken = br; i_mem_busy = busy; i_halt_req = halt; i_resume = res;
        sb.push_back(e);
        #1;
    endtask

    task automatic idle(input logic [24:0] e);
        drive(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0, e);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        drive(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0, E(RST, 0, 0, 0));
        void'(sb.pop_front());
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        @(negedge clk);
        idle(E(RST, 0, 0, 0));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL reset_idle got=%h exp=%h", got_v, exp_v); end
        drive(1, 4'd5, 4'd5, 1, 4'd0, 0, 1, 1, 1, 1, E(RST, 0, 0, 0));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL reset_busy got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        i_reset = 1'b0;
        idle(E(NORM, 0, 0, 0));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL reset_release got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 4'd5, 4'd5, 1, 4'd0, 0, 0, 0, 0, 0, E(LU, 0, 0, 0));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL lu_regA got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        idle(E(NORM, 0, 0, 1));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL lu_after got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        drive(1, 4'd3, 4'd0, 0, 4'd3, 1, 0, 0, 0, 0, E(LU, 0, 0, 1));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL lu_regB got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        drive(1, 4'd0, 4'd0, 1, 4'd9, 0, 0, 0, 0, 0, E(LU, 0, 0, 2));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL lu_r0 got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        idle(E(NORM, 0, 0, 3));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL lu_count got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_no_hazard();
        do_reset();
        drive(1, 4'd5, 4'd5, 0, 4'd5, 0, 0, 0, 0, 0, E(NORM, 0, 0, 0));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL nohz_unused got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        drive(1, 4'd5, 4'd6, 1, 4'd4, 1, 0, 0, 0, 0, E(NORM, 0, 0, 0));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL nohz_diff got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        drive(0, 4'd5, 4'd5, 1, 4'd5, 1, 0, 0, 0, 0, E(NORM, 0, 0, 0));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL nohz_noload got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        idle(E(NORM, 0, 0, 0));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL nohz_count got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_freeze();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'd5, 4'd5, 1, 4'd0, 0, 0, 1, 0, 0, E(FRZ, 0, 0, k));
            got_v = observe(); exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin miscompares++; $display("FAIL freeze[%0d] got=%h exp=%h", k, got_v, exp_v); end
            @(negedge clk);
        end
        drive(1, 4'd5, 4'd5, 1, 4'd0, 0, 0, 0, 0, 0, E(LU, 0, 0, 3));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL freeze_lu got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        idle(E(NORM, 0, 0, 4));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL freeze_after got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_branch();
        do_reset();
        drive(1, 4'd7, 4'd7, 1, 4'd7, 1, 1, 0, 0, 0, E(BR, 0, 0, 0));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL br_lu got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        drive(0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 0, 1, 0, E(BR, 0, 0, 0));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL br_halt got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        // Branch beat halt_req, so the pipe must still be running here.
        drive(0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 1, 0, 0, E(FRZ, 0, 0, 0));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL br_busy got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        idle(E(NORM, 0, 0, 1));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL br_after got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_halt_resume();
        logic [24:0] e;
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            if (k == 0)      e = E(NORM, 0, 0, 0);
            else if (k <= 4) e = E(DRN, 0, 0, 0);
            else if (k <= 7) e = E(HLT, 1, 0, 0);
            else             e = E(NORM, 0, 0, 0);
            drive(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, (k == 0 || k == 2), (k == 7), e);
            got_v = observe(); exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin miscompares++; $display("FAIL halt[%0d] got=%h exp=%h", k, got_v, exp_v); end
            @(negedge clk);
        end
    endtask

    task automatic test_drain_events();
        logic [24:0] e [0:10];
        e[0] = E(NORM, 0, 0, 0); e[1] = E(DRN, 0, 0, 0);  e[2] = E(LU, 0, 0, 0);
        e[3] = E(FRZ, 0, 0, 0);  e[4] = E(DRN, 0, 0, 0);  e[5] = E(BR, 0, 0, 0);
        e[6] = E(DRN, 0, 0, 0);  e[7] = E(HLT, 1, 0, 0);  e[8] = E(FRZ, 1, 0, 0);
        e[9] = E(HLT, 1, 0, 0);  e[10] = E(NORM, 0, 0, 0);
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            drive((k == 2), 4'd2, 4'd2, 1, 4'd0, 0, (k == 5), (k == 3 || k == 8),
                  (k == 0 || k == 4 || k == 9), (k == 1 || k == 9), e[k]);
            got_v = observe(); exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin miscompares++; $display("FAIL drain[%0d] got=%h exp=%h", k, got_v, exp_v); end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_timeout();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1, 0, 0, E(FRZ, 0, 0, k));
            got_v = observe(); exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin miscompares++; $display("FAIL to7[%0d] got=%h exp=%h", k, got_v, exp_v); end
            @(negedge clk);
        end
        idle(E(NORM, 0, 0, 7));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL to7_gap got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        drive(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1, 0, 0, E(FRZ, 0, 0, 7));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL to7_busy got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        idle(E(NORM, 0, 0, 8));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL to7_noerr got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);

        do_reset();
        for (int k = 0; k <= 12; k++) begin
            if (k == 0)      exp_v = E(NORM, 0, 0, 0);
            else if (k <= 8) exp_v = E(FRZ, 0, 0, k - 1);
            else if (k <= 11) exp_v = E(NORM, 0, 1, 8);
            else             exp_v = E(DRN, 0, 1, 8);
            drive(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, (k >= 1 && k <= 8), (k == 11), 0, exp_v);
            got_v = observe(); exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin miscompares++; $display("FAIL to8[%0d] got=%h exp=%h", k, got_v, exp_v); end
            @(negedge clk);
        end
        // Asynchronous reset in the middle of a DRAIN cycle, away from any edge.
        #2;
        i_reset = 1'b1;
        idle(E(RST, 0, 0, 0));
        got_v = observe(); exp_v = sb.pop_front(); vectors++;
        if (got_v !== exp_v) begin miscompares++; $display("FAIL async_rst got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        i_reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            idle(E(NORM, 0, 0, 0));
            got_v = observe(); exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin miscompares++; $display("FAIL post_rst[%0d] got=%h exp=%h", k, got_v, exp_v); end
            @(negedge clk);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_id_registerA = 4'd0; i_id_registerB = 4'd0; i_id_ex_registerRD = 4'd0;
        i_id_useA = 1'b0; i_id_useB = 1'b0; i_id_ex_memRead = 1'b0;
        i_branch_taken = 1'b0; i_mem_busy = 1'b0; i_halt_req = 1'b0; i_resume = 1'b0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_freeze();
        test_branch();
        test_halt_resume();
        test_drain_events();
        test_mem_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
